instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
Fetch stage of the single-issue RV32 core. It owns the program counter and issues word requests to instruction memory over a req/ack handshake. It holds the returned word in an instruction register and presents it to decode with a valid/ready handshake. Its `instruction` output feeds the immediate generator and the control decoder directly. Branch/jump redirects from execute flush the stage and restart fetch at the target.

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013: value driven on `instruction` while reset is asserted (addi x0,x0,0).

Ports:
- clk  input  1: single clock, rising edge.
- rst_n  input  1: reset, asynchronous assert, active-low.
- mem_req  output  1: instruction-memory request.
- mem_addr  output  32: word-aligned fetch address; stable while mem_req=1 and unacked.
- mem_ack  input  1: memory accepted the request; mem_rdata is valid in the same cycle.
- mem_rdata  input  32: fetched instruction word.
- instruction  output  32: held instruction to decode/immediate generator.
- instr_pc  output  32: address of `instruction`.
- instr_valid  output  1: `instruction`/`instr_pc` are valid.
- instr_ready  input  1: decode consumes the instruction this cycle.
- redirect_valid  input  1: execute requests a PC change.
- redirect_pc  input  32: redirect target; bits [1:0] ignored (forced 00).

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - pc=RESET_VECTOR, state=FETCH.
  - mem_req=0, instr_valid=0, instruction=NOP_INSTR, instr_pc=RESET_VECTOR.
  - Pending-target register cleared.
- mem_req is combinational from state: 1 in FETCH and DRAIN, 0 in HOLD and during reset.
  - mem_addr = pc in FETCH; mem_addr = the stale in-flight address in DRAIN.
- First request is visible in the first cycle after rst_n deasserts.
- State FETCH:
  - mem_ack=1, no redirect: instruction<=mem_rdata, instr_pc<=pc, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), instr_valid<=1, go HOLD.
  - Latency is ack cycle N -> instr_valid high at N+1.
  - mem_ack=1 with redirect_valid=1: discard rdata, pc<={redirect_pc[31:2],2'b00}, stay FETCH; instr_valid stays 0.
  - mem_ack=0 with redirect_valid=1: the address must not change mid-request. Latch pending_pc<=aligned target and go DRAIN.
  - mem_ack=0, no redirect: hold all state.
- State DRAIN:
  - mem_req=1 with the old address.
  - A new redirect_valid overwrites pending_pc (the latest redirect wins).
  - On mem_ack: discard rdata, pc<=pending_pc (or the same-cycle redirect target if present), go FETCH.
  - instr_valid=0 throughout.
- State HOLD:
  - instr_valid=1; instruction and instr_pc stable.
  - redirect_valid=1: instr_valid<=0, pc<=aligned target, go FETCH. Redirect has priority over instr_ready in the same cycle; the held instruction is dropped and not counted as consumed.
  - instr_ready=1, no redirect: instr_valid<=0, go FETCH (request next cycle). Peak throughput is 1 instruction per 2 cycles.
  - Neither: hold indefinitely.
- `instruction` keeps its last value while instr_valid=0 and is only rewritten on a kept ack.
- Reset mid-request: state returns to FETCH with mem_req=0 immediately. Any later ack belonging to the abandoned request is ignored, because mem_req is low during reset and a new request starts only after release. Memory must not ack while mem_req=0.
- No ack arrives while in HOLD; an ack with mem_req=0 is ignored.

Optional Feature:
- Macro FETCH_PERF_COUNTER_EN.
- When defined:
  - Adds output ports perf_fetched[31:0] and perf_flushed[31:0], both reset to 0, wrapping at 2^32.
  - perf_fetched increments on each HOLD-state handshake (instr_valid & instr_ready & !redirect_valid).
  - perf_flushed increments once for each fetched word discarded by a redirect: an ack discarded in FETCH or DRAIN, or a held instruction dropped in HOLD.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, then release with mem_ack tied 1, rdata=32'h00500093, instr_ready=1.
   -> mem_req high cycle 1 with mem_addr=0.
   -> instr_valid at cycle 2 with instruction=32'h00500093, instr_pc=0.
   -> Next request at addr 4.
2. Memory acks after 3 wait cycles.
   -> mem_addr stays 32'h8 for all 4 request cycles.
   -> instr_valid rises the cycle after ack.
3. Stall: instr_ready=0 for 5 cycles while in HOLD.
   -> instr_valid, instruction and instr_pc constant; mem_req=0.
4. Redirect to 32'h0000_0103 while an unacked request to 32'h10 is pending.
   -> State DRAIN; the ack to 0x10 is discarded.
   -> Next request to 32'h0000_0100; instr_pc of the next valid instruction = 0x100.
5. redirect_valid and instr_ready asserted together in HOLD.
   -> Instruction dropped; next fetch at the target.
   -> With FETCH_PERF_COUNTER_EN: perf_fetched unchanged, perf_flushed+1.
6. Redirect to 32'hFFFF_FFFC, then consume.
   -> Following request address = 32'h0000_0000 (wrap).
   -> Assert rst_n=0 mid-request: mem_req=0 and instruction=32'h00000013 immediately.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's bus signals: instruction-memory req/ack port,
// decode-side valid/ready port and the execute-stage redirect input.
//
// Handshakes:
//   mem:    mem_req=1 presents mem_addr; mem_ack=1 in the same cycle means the
//           word on mem_rdata belongs to that request. mem_addr stays stable
//           while mem_req=1 and no ack has arrived. Memory never acks while
//           mem_req=0.
//   decode: instr_valid=1 presents instruction/instr_pc. The word is consumed
//           on a cycle with instr_valid=1 and instr_ready=1. instruction and
//           instr_pc stay stable while instr_valid=1 and the word is unconsumed.
//   redirect: a one-cycle pulse on redirect_valid carries redirect_pc; bits
//           [1:0] of the target are ignored.
//
// Modports: master = fetch stage, slave = memory/decode/execute environment.
interface instruction_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, instruction, instr_pc, instr_valid,
    input  mem_ack, mem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instruction, instr_pc, instr_valid,
    output mem_ack, mem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage of the single-issue RV32 core. Owns the PC, requests words from
// instruction memory, holds the returned word for decode and restarts at the
// target on a redirect from execute.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          instruction_fetch_if.master (memory, decode, redirect signals)
//   fetch_state  debug view of the FSM state (0 FETCH, 1 DRAIN, 2 HOLD)
//   perf_fetched / perf_flushed  only when FETCH_PERF_COUNTER_EN is defined:
//                words handed to decode / fetched words thrown away by a
//                redirect; both wrap at 2^32.
//
// Optional feature macro: FETCH_PERF_COUNTER_EN
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_fetch_if.master  bus,
  output logic [1:0]           fetch_state
`ifdef FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_flushed
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pending_pc;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        valid_q;
  logic [31:0] redirect_target;
  logic        unused_redirect_bits;

  assign redirect_target      = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^bus.redirect_pc[1:0];

  // Gated with rst_n so the request drops the moment reset asserts, even
  // though state already reads FETCH. In DRAIN pc is untouched (the new target
  // waits in pending_pc), so pc is still the in-flight address.
  assign bus.mem_req     = rst_n && (state != HOLD);
  assign bus.mem_addr    = pc;
  assign bus.instruction = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign fetch_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      pc           <= RESET_VECTOR;
      pending_pc   <= '0;
      instr_q      <= NOP_INSTR;
      instr_pc_q   <= RESET_VECTOR;
      valid_q      <= 1'b0;
`ifdef FETCH_PERF_COUNTER_EN
      perf_fetched <= '0;
      perf_flushed <= '0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (bus.mem_ack) begin
            if (bus.redirect_valid) begin
              // Word arrived but the path changed in the same cycle.
              pc <= redirect_target;
`ifdef FETCH_PERF_COUNTER_EN
              perf_flushed <= perf_flushed + 32'd1;
`endif
            end else begin
              instr_q    <= bus.mem_rdata;
              instr_pc_q <= pc;
              pc         <= pc + 32'd4;
              valid_q    <= 1'b1;
              state      <= HOLD;
            end
          end else if (bus.redirect_valid) begin
            // Request still open: keep its address and wait for the ack.
            pending_pc <= redirect_target;
            state      <= DRAIN;
          end
        end

        DRAIN: begin
          if (bus.mem_ack) begin
            pc    <= bus.redirect_valid ? redirect_target : pending_pc;
            state <= FETCH;
`ifdef FETCH_PERF_COUNTER_EN
            perf_flushed <= perf_flushed + 32'd1;
`endif
          end else if (bus.redirect_valid) begin
            pending_pc <= redirect_target;
          end
        end

        HOLD: begin
          if (bus.redirect_valid) begin
            // Redirect wins over a same-cycle consume; the word is dropped.
            valid_q <= 1'b0;
            pc      <= redirect_target;
            state   <= FETCH;
`ifdef FETCH_PERF_COUNTER_EN
            perf_flushed <= perf_flushed + 32'd1;
`endif
          end else if (bus.instr_ready) begin
            valid_q <= 1'b0;
            state   <= FETCH;
`ifdef FETCH_PERF_COUNTER_EN
            perf_fetched <= perf_fetched + 32'd1;
`endif
          end
        end

        default: begin
          state   <= FETCH;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
